// File: rtl/regfile_writer.sv
// Write-back sequencer for the register-file write port: captures one request,
// waits for load data when needed, extends/aligns it and issues at most one write.
module regfile_writer #(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [1:0]            wb_sel,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [XLEN-1:0]       data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t                state_r, state_s;
    logic [REG_ADDR_W-1:0] dest_r, dest_s;
    logic [XLEN-1:0]       data_r, data_s;
    logic [2:0]            funct3_r, funct3_s;
    logic [1:0]            addr_lo_r, addr_lo_s;
    logic                  no_write_r, no_write_s;
    logic                  fault_r, fault_s;
    logic [7:0]            cnt_r, cnt_s;
    logic [7:0]            cnt_inc_s;
    logic                  write_enable_r, busy_r, done_r, err_r;

    // Misaligned or illegal load encodings are rejected before any memory wait.
    function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: load_fault = 1'b0;
            3'b001, 3'b101: load_fault = off[0];
            3'b010:         load_fault = (off != 2'b00);
            default:        load_fault = 1'b1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [1:0] off,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_extend = {{(XLEN-8){lane_b[7]}}, lane_b};
            3'b001:  load_extend = {{(XLEN-16){lane_h[15]}}, lane_h};
            3'b010:  load_extend = word;
            3'b100:  load_extend = {{(XLEN-8){1'b0}}, lane_b};
            3'b101:  load_extend = {{(XLEN-16){1'b0}}, lane_h};
            default: load_extend = {XLEN{1'b0}};
        endcase
    endfunction

    assign cnt_inc_s = cnt_r + 8'd1;

    // Next-state and capture logic.
    always_comb begin
        state_s    = state_r;
        dest_s     = dest_r;
        data_s     = data_r;
        funct3_s   = funct3_r;
        addr_lo_s  = addr_lo_r;
        no_write_s = no_write_r;
        fault_s    = fault_r;
        cnt_s      = cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    dest_s     = rd;
                    funct3_s   = funct3;
                    addr_lo_s  = addr_lo;
                    no_write_s = 1'b0;
                    fault_s    = 1'b0;
                    cnt_s      = 8'd0;
                    case (wb_sel)
                        2'b00: begin
                            data_s  = alu_result;
                            state_s = WRITE;
                        end
                        2'b10: begin
                            data_s  = pc_plus4;
                            state_s = WRITE;
                        end
                        2'b11: begin
                            no_write_s = 1'b1;
                            state_s    = WRITE;
                        end
                        default: begin
                            if (load_fault(funct3, addr_lo)) begin
                                fault_s = 1'b1;
                                state_s = WRITE;
                            end else begin
                                state_s = WAIT_MEM;
                            end
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    data_s  = load_extend(funct3_r, addr_lo_r, mem_rdata);
                    state_s = WRITE;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    cnt_s   = cnt_inc_s;
                    fault_s = 1'b1;
                    state_s = WRITE;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            WRITE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, capture registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            dest_r         <= '0;
            data_r         <= '0;
            funct3_r       <= 3'b000;
            addr_lo_r      <= 2'b00;
            no_write_r     <= 1'b0;
            fault_r        <= 1'b0;
            cnt_r          <= 8'd0;
            write_enable_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            state_r        <= state_s;
            dest_r         <= dest_s;
            data_r         <= data_s;
            funct3_r       <= funct3_s;
            addr_lo_r      <= addr_lo_s;
            no_write_r     <= no_write_s;
            fault_r        <= fault_s;
            cnt_r          <= cnt_s;
            write_enable_r <= (state_s == WRITE) && (dest_s != '0) && !no_write_s && !fault_s;
            busy_r         <= (state_s != IDLE);
            done_r         <= (state_s == WRITE);
            err_r          <= (state_s == WRITE) && fault_s;
        end
    end

    assign write_enable = write_enable_r;
    assign dest         = dest_r;
    assign data_in      = data_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;

endmodule

// File: doc/regfile_writer.md
# regfile_writer

Write-back sequencer for the no-pipeline core. It owns the single write port of the ID-stage register file and drives `write_enable`, `dest` and `data_in`. Decode issues one write-back request per instruction. The block captures the request, selects the ALU, PC+4 or load result, and waits for load data where needed. For loads it sign- or zero-extends and lane-aligns the data. It then performs exactly one register-file write, or none for x0, no-write requests and faults, and signals completion to the control unit.

## Interface
- `XLEN`, 32, data width.
- `REG_ADDR_W`, 5, register index width.
- `MEM_TIMEOUT`, 255, maximum cycles spent waiting for load data (8-bit counter range, 1..255).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high. One clock, `clk`.
- `start`  in  1  one-cycle request strobe. Sampled only in IDLE.
- `rd`  in  REG_ADDR_W  destination register.
- `wb_sel`  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 no write.
- `funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `addr_lo`  in  2  load byte offset.
- `alu_result`  in  XLEN  ALU result.
- `pc_plus4`  in  XLEN  link value.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  XLEN  word-aligned load data.
- `write_enable`  out  1  register-file write strobe.
- `dest`  out  REG_ADDR_W  register-file write index.
- `data_in`  out  XLEN  register-file write data.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle fault pulse, coincident with `done`.

## Operation
- States: IDLE, WAIT_MEM, WRITE.
- IDLE, when `start`=1:
  - Latch `rd`, `wb_sel`, `funct3` and `addr_lo`.
  - `wb_sel`=00 or 10: latch `alu_result` or `pc_plus4` and go to WRITE.
  - `wb_sel`=11: go to WRITE with the write suppressed.
  - `wb_sel`=01: check for a fault first. A fault is an illegal `funct3` (011, 110, 111), LH/LHU with `addr_lo[0]`=1, or LW with `addr_lo`≠0. On a fault, go to WRITE with the fault flag set. Otherwise clear the timeout counter and go to WAIT_MEM.
- WAIT_MEM:
  - On `mem_rvalid`=1, extract the byte or halfword at `addr_lo`, sign- or zero-extend per `funct3`, latch the result and go to WRITE.
  - Otherwise increment the counter. When the counter reaches `MEM_TIMEOUT` without valid data, set the fault flag and go to WRITE.
  - `mem_rvalid` outside WAIT_MEM is ignored.
- WRITE, always exactly one cycle, then IDLE:
  - `write_enable` = 1 only if the latched `rd`≠0, the request is not no-write, and the fault flag is clear.
  - `done`=1. `err` = fault flag.
- `dest` and `data_in` are registered outputs, held stable from capture until the next capture.
- `start` while `busy`=1 is ignored: no queueing and no error.
- Arithmetic: extraction is a pure bit-select. Sign extension uses bit 7 or bit 15 of the selected lane.

## Timing
- Reset: state IDLE, all outputs 0 (`write_enable`, `dest`, `data_in`, `busy`, `done`, `err`), counter and fault flag cleared.
- `reset` takes priority over every transition. Asserting it mid-WAIT_MEM or mid-WRITE aborts the operation: no write is issued in the cycle after reset is sampled.
- ALU, PC+4, no-write and immediate-fault requests: `start` sampled on edge T; WRITE, `done`, and `write_enable` (if allowed) are high during cycle T+1; `busy` is high during T+1 only.
- Load: `mem_rvalid` sampled on edge M → WRITE during cycle M+1. If `mem_rvalid` is already high in the first WAIT_MEM cycle, latency from `start` is 2 cycles.
- Timeout: with no `mem_rvalid`, WRITE with `err`=1 occurs exactly `MEM_TIMEOUT`+1 cycles after entering WAIT_MEM.
- `start` sampled in the WRITE cycle is ignored. A new request is accepted earliest on the cycle after `done`, so back-to-back throughput is one request per 2 cycles.
- The register file latches on the same edge that ends the WRITE cycle. Readers see the new value from the following cycle.

## Test plan
- ALU write: `start`, `wb_sel`=00, `rd`=5, `alu_result`=0x1234_5678 → next cycle `write_enable`=1, `dest`=5, `data_in`=0x1234_5678, `done`=1, `err`=0.
- x0 and no-write: `rd`=0 with `wb_sel`=00, then `rd`=7 with `wb_sel`=11 → `done`=1 each time and `write_enable`=0 both times.
- Load extension: `mem_rdata`=0x80FF_7F01, `rvalid` 3 cycles after `start`:
  - LB with `addr_lo`=3 → 0xFFFF_FF80.
  - LBU with `addr_lo`=1 → 0x0000_007F.
  - LH with `addr_lo`=2 → 0xFFFF_80FF.
  - LW → 0x80FF_7F01.
  - Each write occurs on the cycle after `rvalid`.
- Faults: LW with `addr_lo`=2 → `done`=`err`=1 at T+1 and no write. `MEM_TIMEOUT`=4 with no `rvalid` → `err` exactly 5 cycles after WAIT_MEM entry, no write, and a later `rvalid` is ignored.
- Busy and reset: `start` pulses while in WAIT_MEM are ignored. Asserting `reset` in WAIT_MEM followed by `rvalid` → no write, all outputs 0, and the next `start` is accepted normally.
